// File: rtl/rf_write_sched.sv
// Write-port scheduler for the register file: zero-fills NREGS registers after reset, then round-robins NREQ write-back requesters.
// Latency: an accepted request appears on A3/WD3/WE3 right after its accept edge, and the register file captures it on the next edge.
// Backpressure: req_ready is a one-hot grant, held low during zero-fill; a requester holds valid/addr/data until granted, and nothing is buffered here.
module rf_write_sched #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic                     WE3,
    output logic                     init_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     ptr;

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    logic [PW-1:0]     off;
    logic [PW:0]       sum;
    logic [PW-1:0]     gidx;
    logic [PW:0]       nsum;
    logic [PW-1:0]     next_ptr;
    logic [NREQ-1:0]   grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Round-robin pick: rotate valids so ptr sits at bit 0, take the first set bit, then map back to a requester index.
    always_comb begin
        dbl   = {req_valid, req_valid} >> ptr;
        rot   = dbl[NREQ-1:0];
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = PW'(k);
            end
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
        end
        gidx = sum[PW-1:0];
        nsum = {1'b0, gidx} + (PW+1)'(1);
        if (nsum >= (PW+1)'(NREQ)) begin
            nsum = nsum - (PW+1)'(NREQ);
        end
        next_ptr = nsum[PW-1:0];
        grant    = '0;
        if (state == RUN && found) begin
            grant[gidx] = 1'b1;
        end
    end

    // Mux the granted requester's address and data onto the write path.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = grant;

    // Zero-fill sweep followed by arbitrated write-back, with registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            ptr       <= '0;
            A3        <= '0;
            WD3       <= '0;
            WE3       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    A3  <= ADDR_W'(cnt);
                    WD3 <= '0;
                    WE3 <= 1'b1;
                    if (cnt == CW'(NREGS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (found) begin
                        // An accepted write to $0 still consumes the grant, but it never asserts the enable.
                        A3  <= sel_addr;
                        WD3 <= sel_data;
                        WE3 <= (sel_addr != '0);
                        ptr <= next_ptr;
                    end else begin
                        WE3 <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler for the 32×32 register file in the single-cycle MIPS datapath. It owns the file's only write port (A3/WD3/WE3) and runs in two phases. After reset, it sequences a zero-fill of every register. It then shares the port between NREQ write-back requesters (e.g. ALU write-back, load return, multi-cycle unit) using round-robin arbitration and a valid/ready handshake. It also enforces the rule that $0 is never written.

## Interface
- NREQ, 2: number of write requesters (2..8)
- ADDR_W, 5: register address width
- DATA_W, 32: register data width
- NREGS, 32: registers zeroed during init (≤ 2^ADDR_W)

- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*ADDR_W  requester i destination at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot grant; a transfer happens on a rising edge with valid[i]&ready[i]
- A3  out  ADDR_W  register-file write address (registered)
- WD3  out  DATA_W  register-file write data (registered)
- WE3  out  1  register-file write enable (registered)
- init_done  out  1  zero-fill complete; arbitration enabled

## Operation
- States:
  - INIT: counter cnt runs 0..NREGS-1. Each cycle drives A3=cnt, WD3=0, WE3=1. req_ready=0.
  - RUN: entered after cnt reaches NREGS-1. No other transitions; only rst leaves RUN.
- Reset values: state=INIT, cnt=0, rr pointer=0, WE3=0, A3=0, WD3=0, init_done=0, req_ready=0.
- RUN arbitration:
  - Highest priority is requester ptr, then ptr+1, … mod NREQ.
  - req_ready is combinational from req_valid and ptr. Exactly one bit is set, for the first valid requester in priority order. req_ready is 0 when none is valid.
  - A requester never sees ready without its own valid.
- Accept: on the edge where valid[i]&ready[i] holds:
  - A3 and WD3 are loaded from requester i.
  - WE3 is set to 1 if addr≠0, otherwise 0.
  - ptr is set to (i+1) mod NREQ.
- Address 0: the request is accepted and consumes the grant. ptr advances. No write is issued (WE3=0). A3/WD3 still load.
- No accept in a cycle: WE3=0; A3/WD3 hold their previous values; ptr holds.
- Requesters must hold valid/addr/data stable until accepted. The scheduler does not buffer; at most one write is in flight.

## Timing
- Edge numbering: edge 1 is the first rising edge with rst low.
- INIT:
  - At edge k (k=1..NREGS), outputs become A3=k-1, WD3=0, WE3=1.
  - init_done rises at edge NREGS and stays 1 until rst.
- RUN:
  - req_ready may first be high in the cycle after edge NREGS.
  - The earliest accept is edge NREGS+1. The register file captures that write at edge NREGS+2.
- Latency: accept edge → WE3/A3/WD3 valid after the same edge → register file updated on the next edge. Fixed 1-cycle write latency.
- Throughput: one accepted request per cycle, sustained. Back-to-back accepts to the same address are legal; the last one wins.
- Single valid requester: granted every cycle regardless of ptr. Round-robin never blocks it.
- rst asserted at any time, including mid-INIT or on an accept edge: all outputs go to reset values immediately, without waiting for clk. Any in-flight write is dropped (WE3=0). INIT restarts at register 0 after deassertion.

## Test plan
- Reset sweep: release rst with NREGS=32 → WE3=1 with A3=0..31 and WD3=0 on edges 1..32; init_done=1 at edge 32; req_ready=0 throughout INIT.
- Single requester: req0 valid, addr=5, data=0xDEADBEEF at edge 33 → ready0=1; after edge 33, A3=5, WD3=0xDEADBEEF, WE3=1; after edge 34, WE3=0.
- Contention: req0 and req1 held valid continuously from edge 33 → grants alternate 0,1,0,1 on edges 33–36; each requester's addr/data appear on the port after its grant edge.
- $0 drop: req1 alone with addr=0, data=0x1234 → ready1=1 and the request is accepted; WE3 stays 0; ptr advances to 0; the next req0 request is granted immediately.
- Reset mid-INIT: assert rst asynchronously during edge 10's cycle → WE3=0, A3=0, init_done=0 with no clock edge; after release, the sweep restarts at A3=0.
- Reset mid-RUN: assert rst while req0 is granted → req_ready=0 and WE3=0 immediately; after release, INIT runs again and req0 is not accepted until edge 33.
